// File: rtl/display_pkg.sv
// Shared types and seven-segment helpers for the display output stage.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    UPD
  } state_t;

  // Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg7(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/display_ctrl_if.sv
// Datapath-side and board-side signals of the display stage, grouped as one bundle.
interface display_ctrl_if #(
  parameter int DW   = 10,
  parameter int NDIG = 3,
  parameter int TW   = 2
);

  logic [DW-1:0]     BUS;
  logic [DW-1:0]     REG;
  logic [TW-1:0]     TIME;
  logic              DONE;
  logic              PEEKb;
  logic              MODE;
  logic [DW-1:0]     LED_B;
  logic [7*NDIG-1:0] DHEX;
  logic [6:0]        THEX;
  logic              LED_D;
  logic              BUSY;

  // The datapath/board side drives the inputs and observes the pins.
  modport master (
    output BUS, REG, TIME, DONE, PEEKb, MODE,
    input  LED_B, DHEX, THEX, LED_D, BUSY
  );

  // The display controller consumes the inputs and drives the pins.
  modport slave (
    input  BUS, REG, TIME, DONE, PEEKb, MODE,
    output LED_B, DHEX, THEX, LED_D, BUSY
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle, DW steps total.
// Carries enough internal BCD digits to hold any DW-bit value so that values too
// large for NDIG digits are reported through ovf rather than silently truncated.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int DW   = 10,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DW-1:0]     value,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd,
  output logic              ovf
);

  localparam int NDEC = (DW + 2) / 3;
  localparam int NI   = (NDEC > NDIG) ? NDEC : NDIG;
  localparam int CW   = $clog2(DW + 1);

  logic [4*NI-1:0] bcd_q;
  logic [4*NI-1:0] adj;
  logic [DW-1:0]   bin_q;
  logic [CW-1:0]   cnt;
  logic            busy_q;

  // Add 3 to every BCD digit of 5 or more before the next left shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NI; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift one binary bit into the BCD register per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      bcd_q  <= '0;
      bin_q  <= value;
      cnt    <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {adj[4*NI-2:0], bin_q[DW-1]};
      bin_q <= {bin_q[DW-2:0], 1'b0};
      if (cnt == CW'(DW - 1)) begin
        busy_q <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Any nonzero digit beyond the displayed ones means the value does not fit.
  always_comb begin
    ovf = 1'b0;
    for (int i = NDIG; i < NI; i++) ovf = ovf | (|bcd_q[4*i +: 4]);
  end

  // done marks the cycle whose closing edge performs the final shift, so the
  // result is settled in the very next cycle.
  assign done = busy_q && (cnt == CW'(DW - 1));
  assign busy = busy_q;
  assign bcd  = bcd_q[4*NDIG-1:0];

endmodule

// File: rtl/display_ctrl.sv
// Output stage between the processor datapath and the board pins: bus LEDs,
// data digits (hex or decimal, with peek snapshot), timestep digit and done dot.
module display_ctrl
  import display_pkg::*;
#(
  parameter int DW        = 10,
  parameter int NDIG      = 3,
  parameter int TW        = 2,
  parameter int BLINK_DIV = 25_000_000,
  parameter int LZB       = 1
) (
  input logic           CLKb,
  input logic           CLRb,
  display_ctrl_if.slave pins
);

  localparam int HW  = (DW > 4*NDIG) ? DW : 4*NDIG;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t state, next_state;

  logic              peek_s1, peek_s2, peek_s3;
  logic              peek_fall;
  logic [DW-1:0]     snapshot;
  logic [DW-1:0]     src;
  logic [DW-1:0]     cur_val, last_val;
  logic              cur_mode, last_mode;
  logic              busy, load_en, conv_start, upd_en;
  logic              conv_busy, conv_done, conv_ovf;
  logic [4*NDIG-1:0] conv_bcd;
  logic [HW-1:0]     hex_ext;
  logic              hex_ovf, show_dash, seen;
  logic [3:0]        digit [NDIG];
  logic [7*NDIG-1:0] dhex_next, dhex_q;
  logic [DW-1:0]     led_b;
  logic [6:0]        thex;
  logic              done_q, led_d;
  logic [BCW-1:0]    blink_cnt;

  // Two-stage synchroniser for the peek button plus one stage for edge detection.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      peek_s1 <= 1'b1;
      peek_s2 <= 1'b1;
      peek_s3 <= 1'b1;
    end else begin
      peek_s1 <= pins.PEEKb;
      peek_s2 <= peek_s1;
      peek_s3 <= peek_s2;
    end
  end

  assign peek_fall = peek_s3 & ~peek_s2;

  // Snapshot the bus on the press so the display source switches to a fresh value.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) snapshot <= '0;
    else if (peek_fall) snapshot <= pins.BUS;
  end

  assign src = peek_s3 ? pins.REG : snapshot;

  // FSM state register.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) state <= IDLE;
    else state <= next_state;
  end

  // Next state: convert only when the source/mode differ from what is on display.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if ({src, pins.MODE} != {last_val, last_mode}) next_state = LOAD;
      LOAD:  next_state = pins.MODE ? SHIFT : UPD;
      SHIFT: if (conv_done || !conv_busy) next_state = UPD;
      UPD:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy       = (state != IDLE);
    load_en    = (state == LOAD);
    conv_start = (state == LOAD) && pins.MODE;
    upd_en     = (state == UPD);
  end

  // Latch the value being converted so later source changes cannot tear it.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      cur_val  <= '0;
      cur_mode <= 1'b0;
    end else if (load_en) begin
      cur_val  <= src;
      cur_mode <= pins.MODE;
    end
  end

  // Remember what the digits currently show.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      last_val  <= '0;
      last_mode <= 1'b0;
    end else if (upd_en) begin
      last_val  <= cur_val;
      last_mode <= cur_mode;
    end
  end

  bin2bcd_seq #(
    .DW   (DW),
    .NDIG (NDIG)
  ) u_bin2bcd (
    .clk   (CLKb),
    .rst_n (CLRb),
    .start (conv_start),
    .value (src),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Build the digit patterns: overflow dashes, leading-zero blanking, segment decode.
  always_comb begin
    hex_ext   = HW'(cur_val);
    hex_ovf   = |(hex_ext >> (4*NDIG));
    show_dash = cur_mode ? conv_ovf : hex_ovf;
    digit     = '{default: '0};
    dhex_next = '0;
    seen      = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      digit[i] = cur_mode ? conv_bcd[4*i +: 4] : hex_ext[4*i +: 4];
      if (digit[i] != 4'd0) seen = 1'b1;
      if (show_dash) dhex_next[7*i +: 7] = SEG_DASH;
      else if ((LZB != 0) && !seen && (i != 0)) dhex_next[7*i +: 7] = SEG_BLANK;
      else dhex_next[7*i +: 7] = seg7(digit[i]);
    end
  end

  // All data digits change together, only on the update cycle.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) dhex_q <= {NDIG{SEG_BLANK}};
    else if (upd_en) dhex_q <= dhex_next;
  end

  // Bus LEDs and timestep digit simply follow their inputs one cycle later.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      led_b <= '0;
      thex  <= SEG_BLANK;
    end else begin
      led_b <= pins.BUS;
      thex  <= seg7(4'(pins.TIME));
    end
  end

  // Done dot: lights on the rising edge of DONE, then blinks while DONE stays high.
  always_ff @(posedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      done_q    <= 1'b0;
      led_d     <= 1'b0;
      blink_cnt <= '0;
    end else begin
      done_q <= pins.DONE;
      if (!pins.DONE) begin
        led_d     <= 1'b0;
        blink_cnt <= '0;
      end else if (!done_q) begin
        led_d     <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BCW'(BLINK_DIV - 1)) begin
        led_d     <= ~led_d;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign pins.LED_B = led_b;
  assign pins.DHEX  = dhex_q;
  assign pins.THEX  = thex;
  assign pins.LED_D = led_d;
  assign pins.BUSY  = busy;

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: stimulus queues expected digit patterns,
// a monitor compares them whenever a conversion finishes (BUSY falls).
module tb_display_ctrl;

  localparam int DW        = 10;
  localparam int NDIG      = 3;
  localparam int TW        = 2;
  localparam int BLINK_DIV = 4;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S9 = 7'h10, SA = 7'h08;
  localparam logic [6:0] SF = 7'h0E, BL = 7'h7F, DS = 7'h3F;

  typedef struct packed {
    logic [20:0] dhex;
    int          issue;
    int          lat;
  } exp_t;

  logic CLKb = 1'b0;
  logic CLRb = 1'b1;

  display_ctrl_if #(.DW(DW), .NDIG(NDIG), .TW(TW)) pins ();

  display_ctrl #(
    .DW        (DW),
    .NDIG      (NDIG),
    .TW        (TW),
    .BLINK_DIV (BLINK_DIV),
    .LZB       (1)
  ) dut (
    .CLKb (CLKb),
    .CLRb (CLRb),
    .pins (pins)
  );

  always #5 CLKb = ~CLKb;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  exp_t  sb_q[$];
  string name_q[$];

  always @(posedge CLKb) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_dhex(input string name, input logic [20:0] d, input int lat);
    exp_t e;
    e.dhex  = d;
    e.issue = cyc;
    e.lat   = lat;
    sb_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic apply_stimulus(input string name, input logic [DW-1:0] reg_v, input logic mode_v,
                                input logic [20:0] d, input int lat);
    @(posedge CLKb); #1;
    pins.REG  = reg_v;
    pins.MODE = mode_v;
    expect_dhex(name, d, lat);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || pins.BUSY) && n < 60) begin
      @(negedge CLKb);
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || pins.BUSY) begin
      errors++;
      $display("[TB] FAIL %s_timeout: pending %0d busy %0b, expected none pending and idle",
               name, sb_q.size(), pins.BUSY);
      sb_q.delete();
      name_q.delete();
    end
  endtask

  // Monitor: each completed conversion must match the oldest queued expectation.
  initial begin
    logic  prev_busy;
    exp_t  e;
    string nm;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLKb);
      if (!CLRb) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !pins.BUSY) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_update: got DHEX %h, expected no update", pins.DHEX);
          end else begin
            e  = sb_q.pop_front();
            nm = name_q.pop_front();
            check_output({nm, "_dhex"}, 32'(pins.DHEX), 32'(e.dhex));
            if (e.lat != 0) check_output({nm, "_latency"}, 32'(cyc - e.issue), 32'(e.lat));
          end
        end
        prev_busy = pins.BUSY;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    pins.BUS   = '0;
    pins.REG   = '0;
    pins.TIME  = '0;
    pins.DONE  = 1'b0;
    pins.PEEKb = 1'b1;
    pins.MODE  = 1'b0;

    // Reset state held for five cycles.
    #2 CLRb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLKb);
      check_output("rst_dhex", 32'(pins.DHEX), 32'({BL, BL, BL}));
      check_output("rst_thex", 32'(pins.THEX), 32'(BL));
      check_output("rst_led_b", 32'(pins.LED_B), 32'd0);
      check_output("rst_led_d", 32'(pins.LED_D), 32'd0);
      check_output("rst_busy", 32'(pins.BUSY), 32'd0);
    end
    @(posedge CLKb); #1 CLRb = 1'b1;
    @(posedge CLKb); @(negedge CLKb);
    check_output("post_rst_thex", 32'(pins.THEX), 32'(S0));
    check_output("post_rst_busy", 32'(pins.BUSY), 32'd0);
    check_output("post_rst_dhex", 32'(pins.DHEX), 32'({BL, BL, BL}));

    // Bus LEDs and timestep digit, one-cycle latency.
    @(posedge CLKb); #1;
    pins.BUS  = 10'h155;
    pins.TIME = 2'd3;
    @(negedge CLKb);
    check_output("led_b_before", 32'(pins.LED_B), 32'd0);
    @(posedge CLKb); @(negedge CLKb);
    check_output("led_b_after", 32'(pins.LED_B), 32'h155);
    check_output("thex_3", 32'(pins.THEX), 32'(S3));

    // Hex display and leading-zero blanking.
    apply_stimulus("hex_2a5", 10'h2A5, 1'b0, {S2, SA, S5}, 3);
    wait_idle("hex_2a5");
    apply_stimulus("hex_005", 10'h005, 1'b0, {BL, BL, S5}, 3);
    wait_idle("hex_005");

    // Decimal display, overflow and zero.
    apply_stimulus("dec_999", 10'd999, 1'b1, {S9, S9, S9}, 13);
    @(posedge CLKb); @(negedge CLKb);
    check_output("dec_999_busy", 32'(pins.BUSY), 32'd1);
    wait_idle("dec_999");
    apply_stimulus("dec_1000", 10'd1000, 1'b1, {DS, DS, DS}, 13);
    wait_idle("dec_1000");
    apply_stimulus("dec_0", 10'd0, 1'b1, {BL, BL, S0}, 13);
    wait_idle("dec_0");

    // Peek snapshot.
    apply_stimulus("hex_123", 10'h123, 1'b0, {S1, S2, S3}, 3);
    wait_idle("hex_123");
    @(posedge CLKb); #1 pins.BUS = 10'h3FF;
    @(posedge CLKb); #1 pins.PEEKb = 1'b0;
    expect_dhex("peek_3ff", {S3, SF, SF}, 0);
    wait_idle("peek_3ff");
    @(posedge CLKb); #1 pins.BUS = 10'h0AA;
    repeat (10) @(negedge CLKb);
    check_output("peek_hold", 32'(pins.DHEX), 32'({S3, SF, SF}));
    @(posedge CLKb); #1 pins.PEEKb = 1'b1;
    expect_dhex("peek_release", {S1, S2, S3}, 0);
    wait_idle("peek_release");

    // Source change during a decimal conversion: old value first, then new.
    apply_stimulus("dec_291_old", 10'd291, 1'b1, {S2, S9, S1}, 13);
    repeat (5) @(posedge CLKb);
    #1 pins.REG = 10'd512;
    expect_dhex("dec_512_new", {S5, S1, S2}, 0);
    wait_idle("dec_midshift");

    // Done dot: lit for 4 cycles, dark for 4, lit for 4, then cleared.
    @(posedge CLKb); #1 pins.DONE = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge CLKb); @(negedge CLKb);
      check_output($sformatf("led_d_blink_%0d", k), 32'(pins.LED_D), (((k - 1) / 4) % 2 == 0) ? 32'd1 : 32'd0);
    end
    pins.DONE = 1'b0;
    @(posedge CLKb); @(negedge CLKb);
    check_output("led_d_clear", 32'(pins.LED_D), 32'd0);
    @(posedge CLKb); @(negedge CLKb);
    check_output("led_d_stay", 32'(pins.LED_D), 32'd0);

    // Reset in the middle of a decimal conversion, then automatic reconversion.
    @(posedge CLKb); #1 pins.REG = 10'd777;
    repeat (5) @(posedge CLKb);
    #1 CLRb = 1'b0;
    @(negedge CLKb);
    check_output("midrst_dhex", 32'(pins.DHEX), 32'({BL, BL, BL}));
    check_output("midrst_busy", 32'(pins.BUSY), 32'd0);
    check_output("midrst_thex", 32'(pins.THEX), 32'(BL));
    check_output("midrst_led_b", 32'(pins.LED_B), 32'd0);
    repeat (2) @(posedge CLKb);
    #1 CLRb = 1'b1;
    expect_dhex("reset_reconvert", {S7, S7, S7}, 13);
    wait_idle("reset_reconvert");

    repeat (3) @(negedge CLKb);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
